branch_predictor: RTL
=====================

# branch_predictor

Fetch-side branch predictor and redirect generator. It is the initiator counterpart to the EX-stage jump/branch resolver. In IF it looks up the current PC in a direct-mapped branch target buffer (BTB) and supplies a predicted next PC. In EX it takes the resolver's actual outcome, detects mispredictions, produces the redirect PC and flush, and trains the BTB and its 2-bit saturating counters.

## Interface
Parameters:
- ENTRIES, 16, BTB depth; power of two, ≥2; IDX = log2(ENTRIES).
- XLEN, 32, PC/target width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- if_pc  in  XLEN  PC being fetched.
- pred_taken  out  1  prediction for if_pc.
- pred_target  out  XLEN  predicted next PC.
- upd_valid  in  1  resolved control-transfer instruction in EX this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_j_type  in  2  00 none, 01 JAL, 10 JALR, 11 BRANCH.
- upd_taken  in  1  actual direction; 1 for any JAL/JALR.
- upd_target  in  XLEN  actual target address.
- upd_pred_taken  in  1  prediction made for this instruction, piped from IF.
- upd_pred_target  in  XLEN  predicted next PC, piped from IF.
- flush  out  1  squash IF/ID; a misprediction was detected.
- redirect_pc  out  XLEN  correct next PC when flush=1.
- mispred_cnt  out  16  saturating misprediction count.

## Operation
- Entry fields: valid, tag = pc[XLEN-1:IDX+2], target, j_type, ctr[1:0].
- Lookup (combinational):
  - idx = if_pc[IDX+1:2].
  - hit = valid && tag match.
  - pred_taken = hit && (j_type ∈ {JAL, JALR} || ctr[1]).
  - pred_target = pred_taken ? entry.target : if_pc+4, with modulo 2^XLEN wrap.
- Redirect (combinational):
  - flush = upd_valid && upd_j_type≠00 && (upd_pred_taken≠upd_taken || (upd_taken && upd_pred_target≠upd_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - When flush=0, redirect_pc is don't-care, but it must be deterministic.
- Training happens at the clock edge when upd_valid && upd_j_type≠00:
  - Miss: allocate the entry and overwrite any victim. Set valid=1, tag, j_type and target=upd_target. Set ctr = upd_taken ? 10 : 01.
  - Hit on a BRANCH: saturating ctr increment if taken, decrement if not taken (00↔11 bounds). Overwrite target only when taken.
  - Hit on JAL/JALR: ctr=11; overwrite target and j_type.
- upd_j_type=00 with upd_valid=1: no write, no flush, no count.
- mispred_cnt increments by 1 on every cycle with flush=1 and holds at 16'hFFFF.

## Timing
- Lookup latency is 0 cycles. A training write is visible to a lookup on the next cycle.
- If a lookup and an update hit the same index in the same cycle, the lookup sees the pre-update contents.
- flush and redirect_pc are valid in the same cycle as upd_valid. The PC register consumes them at the next edge, and flush has priority over pred_target.
- Reset (async assert, sync-safe deassert):
  - All valid bits clear to 0, all ctr to 01, mispred_cnt to 0.
  - Result: pred_taken=0, pred_target=if_pc+4, flush=0.
- Reset asserted mid-operation discards all training immediately. An update presented in the same cycle as reset deassertion's first edge is taken normally.
- Addresses with if_pc[1:0]≠0 use the same indexing; low bits are ignored.

## Structure
- Shared package holds:
  - j_type codes: JT_NONE=00, JT_JAL=01, JT_JALR=10, JT_BRANCH=11. These are the same encoding as the resolver.
  - Counter states: SNT=00, WNT=01, WT=10, ST=11.
- Sub-module sat_cnt2 computes the combinational 2-bit saturating next value from (ctr, taken). The BTB storage is flop arrays in the top module.

## Test plan
- Reset, then if_pc=0x100 → pred_taken=0, pred_target=0x104, flush=0, mispred_cnt=0.
- Update BRANCH at pc=0x100, taken, target=0x80, upd_pred_taken=0:
  - Same cycle → flush=1, redirect_pc=0x80.
  - Next cycle, lookup 0x100 → pred_taken=1, pred_target=0x80, mispred_cnt=1.
- Three not-taken updates at 0x100 after the previous case: ctr 10→01→00→00.
  - Lookup → pred_taken=0.
  - Not-taken while predicted taken → flush=1, redirect_pc=0x104.
- JALR at 0x200, target 0x300, then target 0x340 with upd_pred_target=0x300 → flush=1, redirect_pc=0x340; the next lookup predicts 0x340.
- Alias (ENTRIES=16): train 0x100, then update 0x140 (same idx, different tag) → lookup 0x100 misses (pred_target=0x104).
- Force 65536 mispredictions → mispred_cnt=0xFFFF and holds. Assert rst_n low mid-run → all BTB entries invalid and the count is 0 asynchronously.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared control-transfer and counter encodings.
// j_type codes match the EX-stage resolver.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        JT_NONE   = 2'b00,
        JT_JAL    = 2'b01,
        JT_JALR   = 2'b10,
        JT_BRANCH = 2'b11
    } jtype_e;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

endpackage

// File: rtl/branch_predictor_sat_cnt2.sv
// branch_predictor_sat_cnt2: next value of a 2-bit saturating direction counter.
module branch_predictor_sat_cnt2
    import branch_predictor_pkg::*;
(
    input  ctr_e ctr_i,
    input  logic taken_i,
    output ctr_e ctr_o
);

    always_comb
        ctr_o = taken_i ? (ctr_i == ST  ? ST  : ctr_e'(ctr_i + 2'd1))
                        : (ctr_i == SNT ? SNT : ctr_e'(ctr_i - 2'd1));

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB lookup in IF, misprediction redirect and
// BTB training in EX.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [1:0]      upd_j_type,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic [15:0]     mispred_cnt
);

    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = XLEN - IDX - 2;

    logic            valid_q [ENTRIES];
    logic [TW-1:0]   tag_q   [ENTRIES];
    logic [XLEN-1:0] tgt_q   [ENTRIES];
    jtype_e          jt_q    [ENTRIES];
    ctr_e            ctr_q   [ENTRIES];
    logic [15:0]     cnt_q, cnt_d;

    logic [IDX-1:0] l_idx, u_idx;
    logic           l_hit, u_hit, u_act, tgt_we;
    ctr_e           sat, ctr_d;

    branch_predictor_sat_cnt2 u_sat (
        .ctr_i   (ctr_q[u_idx]),
        .taken_i (upd_taken),
        .ctr_o   (sat)
    );

    always_comb begin
        l_idx       = if_pc[IDX+1:2];
        l_hit       = valid_q[l_idx] && tag_q[l_idx] == if_pc[XLEN-1:IDX+2];
        pred_taken  = l_hit && (jt_q[l_idx] == JT_JAL || jt_q[l_idx] == JT_JALR || ctr_q[l_idx][1]);
        pred_target = pred_taken ? tgt_q[l_idx] : if_pc + XLEN'(4);
        u_idx       = upd_pc[IDX+1:2];
        u_hit       = valid_q[u_idx] && tag_q[u_idx] == upd_pc[XLEN-1:IDX+2];
        u_act       = upd_valid && upd_j_type != JT_NONE;
        flush       = u_act && (upd_pred_taken != upd_taken ||
                                (upd_taken && upd_pred_target != upd_target));
        redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);
        // Branch hits keep their old target when not taken; everything else rewrites it
        ctr_d       = !u_hit ? (upd_taken ? WT : WNT) : (upd_j_type == JT_BRANCH ? sat : ST);
        tgt_we      = !u_hit || upd_j_type != JT_BRANCH || upd_taken;
        cnt_d       = (flush && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
        mispred_cnt = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                jt_q[i]    <= JT_NONE;
                ctr_q[i]   <= WNT;
            end
            cnt_q <= '0;
        end else begin
            if (u_act) begin
                valid_q[u_idx] <= 1'b1;
                tag_q[u_idx]   <= upd_pc[XLEN-1:IDX+2];
                jt_q[u_idx]    <= jtype_e'(upd_j_type);
                ctr_q[u_idx]   <= ctr_d;
                if (tgt_we)
                    tgt_q[u_idx] <= upd_target;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule
